// File: rtl/smooth_avg_pkg.sv
// Shared defaults and the rounding helper for the moving-average smoother.
package smooth_avg_pkg;

  localparam int DW_DEF       = 16;
  localparam int WLOG_MAX_DEF = 4;

  // Half of one output LSB for a shift of 'win'; zero when the window is a single sample.
  function automatic int unsigned half_lsb(input logic [2:0] win);
    return (win == 3'd0) ? 32'd0 : (32'd1 << (win - 3'd1));
  endfunction

endpackage

// File: rtl/smooth_ram.sv
// Sample buffer: one write port, one registered read port, read-before-write on address collision.
module smooth_ram
  import smooth_avg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = WLOG_MAX_DEF
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/smooth_avg.sv
// Power-of-two moving-average smoother with runtime window, warm-up masking and bypass.
// ad_vld / sm_vld are one-cycle strobes with no ready: every ad_vld sample is accepted, sm_vld qualifies sm_data for that cycle only.
module smooth_avg
  import smooth_avg_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int WLOG_MAX = WLOG_MAX_DEF
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic [DW-1:0]       ad_data,
  input  logic                ad_vld,
  input  logic [2:0]          cfg_win,
  input  logic                cfg_bypass,
  output logic [DW-1:0]       sm_data,
  output logic                sm_vld,
  output logic [WLOG_MAX:0]   stu_fill
);

  localparam int SW = DW + WLOG_MAX;
  localparam int FW = WLOG_MAX + 1;

  logic [2:0]          r_win_q;
  logic [WLOG_MAX-1:0] r_wr_ptr;
  logic [FW-1:0]       r_fill;
  logic [SW-1:0]       r_sum;
  logic                r_s1_vld;
  logic                r_s1_byp;
  logic                r_s1_old_ok;
  logic                r_s1_full;
  logic [DW-1:0]       r_s1_new;
  logic [DW-1:0]       r_sm_data;
  logic                r_sm_vld;

  logic [2:0]          w_win_c;
  logic                w_flush;
  logic [FW-1:0]       w_wsize;
  logic [FW-1:0]       w_fill_base;
  logic [FW-1:0]       w_fill_inc;
  logic [WLOG_MAX-1:0] w_rd_addr;
  logic [DW-1:0]       w_ram_rdata;
  logic [DW-1:0]       w_oldest;
  logic [SW-1:0]       w_sum_next;
  logic [SW-1:0]       w_rnd;
  logic [DW-1:0]       w_avg;

  assign w_win_c     = (cfg_win > 3'(WLOG_MAX)) ? 3'(WLOG_MAX) : cfg_win;
  assign w_flush     = (w_win_c != r_win_q);
  // Outside a flush w_win_c equals r_win_q, so stage 1 can always use the clamped input.
  assign w_wsize     = FW'(1) << w_win_c;
  assign w_fill_base = w_flush ? '0 : r_fill;
  assign w_fill_inc  = (w_fill_base == w_wsize) ? w_wsize : w_fill_base + FW'(1);
  assign w_rd_addr   = r_wr_ptr - w_wsize[WLOG_MAX-1:0];

  smooth_ram #(
    .DW (DW),
    .AW (WLOG_MAX)
  ) u_ram (
    .clk     (clk_sys),
    .i_we    (ad_vld),
    .i_waddr (r_wr_ptr),
    .i_wdata (ad_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_rdata)
  );

  // Until the window has filled, the buffer word is stale and counts as zero.
  assign w_oldest   = r_s1_old_ok ? w_ram_rdata : '0;
  assign w_sum_next = r_sum + SW'(r_s1_new) - SW'(w_oldest);
  assign w_rnd      = w_sum_next + SW'(half_lsb(r_win_q));
  assign w_avg      = DW'(w_rnd >> r_win_q);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_win_q     <= '0;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_sum       <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_byp    <= 1'b0;
      r_s1_old_ok <= 1'b0;
      r_s1_full   <= 1'b0;
      r_s1_new    <= '0;
      r_sm_data   <= '0;
      r_sm_vld    <= 1'b0;
    end else begin
      r_win_q  <= w_win_c;
      r_s1_vld <= ad_vld;
      r_s1_byp <= cfg_bypass;
      if (ad_vld) begin
        r_s1_new    <= ad_data;
        r_s1_old_ok <= (w_fill_base == w_wsize);
        r_s1_full   <= (w_fill_inc == w_wsize);
        r_fill      <= w_fill_inc;
        r_wr_ptr    <= r_wr_ptr + WLOG_MAX'(1);
      end else if (w_flush) begin
        r_fill <= '0;
      end
      // A flush discards the stage-2 sample already in flight.
      if (w_flush) begin
        r_sum    <= '0;
        r_sm_vld <= 1'b0;
      end else begin
        r_sm_vld <= r_s1_vld & (r_s1_full | r_s1_byp);
        if (r_s1_vld) begin
          r_sum     <= w_sum_next;
          r_sm_data <= r_s1_byp ? r_s1_new : w_avg;
        end
      end
    end
  end

  assign sm_data  = r_sm_data;
  assign sm_vld   = r_sm_vld;
  assign stu_fill = r_fill;

endmodule

// File: tb/tb_smooth_avg.sv
// Bench for smooth_avg: directed scenarios plus random traffic against a queue-based averaging model.
module tb_smooth_avg;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [15:0] ad_data;
  logic        ad_vld;
  logic [2:0]  cfg_win;
  logic        cfg_bypass;
  logic [15:0] sm_data;
  logic        sm_vld;
  logic [4:0]  stu_fill;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int unsigned hist[$];
  logic [15:0] exp_q[$];
  int          m_win = 0;
  logic        p1_vld = 1'b0;
  logic        p1_emit = 1'b0;
  logic [15:0] p1_data = '0;
  logic        m_out_vld = 1'b0;

  smooth_avg #(.DW(16), .WLOG_MAX(4)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .ad_data    (ad_data),
    .ad_vld     (ad_vld),
    .cfg_win    (cfg_win),
    .cfg_bypass (cfg_bypass),
    .sm_data    (sm_data),
    .sm_vld     (sm_vld),
    .stu_fill   (stu_fill)
  );

  // Clock / reset block
  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Rounded mean of the last W accepted samples (W = 1 << m_win), half rounds up.
  function automatic logic [15:0] ref_avg();
    longint unsigned s = 0;
    longint unsigned w = longint'(1) << m_win;
    foreach (hist[i]) s += hist[i];
    return 16'((s + w / 2) / w);
  endfunction

  // Scoreboard update for the inputs sampled at this clock edge.
  task automatic model_edge();
    int  wc;
    bit  flush;
    if (!rst_n) begin
      m_win     = 0;
      hist.delete();
      exp_q.delete();
      p1_vld    = 1'b0;
      m_out_vld = 1'b0;
    end else begin
      wc        = (int'(cfg_win) > 4) ? 4 : int'(cfg_win);
      flush     = (wc != m_win);
      m_out_vld = !flush && p1_vld && p1_emit;
      if (m_out_vld) exp_q.push_back(p1_data);
      if (flush) begin
        hist.delete();
        m_win = wc;
      end
      p1_vld = ad_vld;
      if (ad_vld) begin
        hist.push_back(int'(ad_data));
        if (hist.size() > (1 << m_win)) void'(hist.pop_front());
        p1_emit = cfg_bypass || (hist.size() == (1 << m_win));
        p1_data = cfg_bypass ? ad_data : ref_avg();
      end
    end
  endtask

  task automatic compare();
    check_eq("sm_vld", 32'(sm_vld), 32'(m_out_vld));
    check_eq("stu_fill", 32'(stu_fill), 32'(hist.size()));
    if (m_out_vld) check_eq("sm_data", 32'(sm_data), 32'(exp_q.pop_front()));
    if (!rst_n) check_eq("rst_sm_data", 32'(sm_data), 32'd0);
  endtask

  // Driver: apply one cycle of inputs, update the model at the edge, check just after it.
  task automatic step(input logic vld, input logic [15:0] data, input logic [2:0] win,
                      input logic byp, input logic rst_ok);
    rst_n      = rst_ok;
    ad_vld     = vld;
    ad_data    = data;
    cfg_win    = win;
    cfg_bypass = byp;
    @(posedge clk_sys);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    logic [2:0]  r_win;
    logic        r_byp;

    rst_n = 1'b0; ad_vld = 1'b0; ad_data = '0; cfg_win = 3'd2; cfg_bypass = 1'b0;
    repeat (3) step(1'b0, 16'd0, 3'd2, 1'b0, 1'b0);

    // Ramp with W = 4
    for (int i = 1; i <= 10; i++) step(1'b1, 16'(i), 3'd2, 1'b0, 1'b1);
    repeat (3) step(1'b0, 16'd0, 3'd2, 1'b0, 1'b1);

    // Full-scale constant with W = depth
    for (int i = 0; i < 24; i++) step(1'b1, 16'hFFFF, 3'd4, 1'b0, 1'b1);
    repeat (2) step(1'b0, 16'd0, 3'd4, 1'b0, 1'b1);

    // W = 1, then an out-of-range window clamped to 16
    for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom_range(0, 65535)), 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 16'($urandom_range(0, 65535)), 3'd7, 1'b0, 1'b1);
    repeat (2) step(1'b0, 16'd0, 3'd7, 1'b0, 1'b1);

    // Window change while a constant stream flows
    for (int i = 0; i < 8; i++) step(1'b1, 16'd100, 3'd2, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 16'd100, 3'd1, 1'b0, 1'b1);

    // Bypass through warm-up, then release
    for (int i = 0; i < 20; i++) step(1'b1, 16'd50, 3'd3, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 16'd50, 3'd3, 1'b0, 1'b1);

    // Reset between two in-flight samples
    for (int i = 0; i < 6; i++) step(1'b1, 16'($urandom_range(0, 1000)), 3'd2, 1'b0, 1'b1);
    step(1'b0, 16'd0, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom_range(0, 1000)), 3'd2, 1'b0, 1'b1);

    // Random traffic: gaps, window changes, bypass toggles, occasional resets
    r_win = 3'd2;
    r_byp = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) r_win = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) r_byp = ~r_byp;
      step(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)), r_win, r_byp,
           ($urandom_range(0, 149) != 0));
    end
    repeat (3) step(1'b0, 16'd0, r_win, r_byp, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
